// File: rtl/fire_pkg.sv
// Shared types and helpers for the multi-zone fire controller.
// Optional feature macro used by the top: FIRE_PREALARM_EN.
package fire_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VERIFY    = 3'd1,
        ALARM     = 3'd2,
        DISCHARGE = 3'd3,
        HOLD      = 3'd4
    } zone_state_e;

    // Width of the per-zone counter, sized for the longest of the three timed phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fire_zone_fsm.sv
// One zone: confirm -> alarm delay -> timed discharge -> latched hold until ack.
// A single counter serves every timed state and clears on each state change.
module fire_zone_fsm
    import fire_pkg::*;
#(
    parameter int CONFIRM_CYCLES   = 16,
    parameter int DISCHARGE_DELAY  = 64,
    parameter int DISCHARGE_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic abort,
    input  logic ack,
    output logic alarm,
    output logic extinguisher,
    output logic alarm_next,
    output logic quiet
);

    localparam int CW = cnt_width(CONFIRM_CYCLES, DISCHARGE_DELAY, DISCHARGE_CYCLES);

    zone_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (fire) begin
                    if (CONFIRM_CYCLES == 1) begin
                        state_n = ALARM;
                        cnt_n   = '0;
                    end else begin
                        state_n = VERIFY;
                        cnt_n   = CW'(1);
                    end
                end
            end
            VERIFY: begin
                if (!fire) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(CONFIRM_CYCLES - 1)) begin
                    state_n = ALARM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ALARM: begin
                // abort outranks everything here; ack and fire are ignored
                if (abort) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == CW'(DISCHARGE_DELAY - 1)) begin
                    state_n = DISCHARGE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DISCHARGE: begin
                if (abort || cnt == CW'(DISCHARGE_CYCLES - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (ack && !fire) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign alarm_next = (state_n == ALARM) || (state_n == DISCHARGE) || (state_n == HOLD);
    assign quiet      = (state == IDLE) || (state == VERIFY);

    // Outputs are flops loaded from next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            alarm        <= 1'b0;
            extinguisher <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            alarm        <= alarm_next;
            extinguisher <= (state_n == DISCHARGE);
        end
    end

endmodule

// File: rtl/fire_zone_controller.sv
// Multi-zone fire controller: one independent FSM per zone, shared ack.
// Define FIRE_PREALARM_EN to add the registered prealarm (smoke xor heat) output.
module fire_zone_controller
    import fire_pkg::*;
#(
    parameter int ZONES            = 4,
    parameter int CONFIRM_CYCLES   = 16,
    parameter int DISCHARGE_DELAY  = 64,
    parameter int DISCHARGE_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ZONES-1:0] smoke,
    input  logic [ZONES-1:0] heat,
    input  logic [ZONES-1:0] abort,
    input  logic             ack,
    output logic [ZONES-1:0] alarm,
    output logic [ZONES-1:0] extinguisher,
`ifdef FIRE_PREALARM_EN
    output logic [ZONES-1:0] prealarm,
`endif
    output logic             any_alarm
);

    logic [ZONES-1:0] alarm_next;
    logic [ZONES-1:0] quiet;

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        fire_zone_fsm #(
            .CONFIRM_CYCLES  (CONFIRM_CYCLES),
            .DISCHARGE_DELAY (DISCHARGE_DELAY),
            .DISCHARGE_CYCLES(DISCHARGE_CYCLES)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .fire        (smoke[z] & heat[z]),
            .abort       (abort[z]),
            .ack         (ack),
            .alarm       (alarm[z]),
            .extinguisher(extinguisher[z]),
            .alarm_next  (alarm_next[z]),
            .quiet       (quiet[z])
        );
    end

    // Reduce next-state alarms so any_alarm stays aligned with alarm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_alarm <= 1'b0;
        else     any_alarm <= |alarm_next;
    end

`ifdef FIRE_PREALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prealarm <= '0;
        else     prealarm <= (smoke ^ heat) & quiet;
    end
`else
    logic unused_quiet;
    assign unused_quiet = ^quiet;
`endif

endmodule

// File: tb/tb_fire_zone_controller.sv
// Scoreboard bench for fire_zone_controller (ZONES=4, CONFIRM=4, DELAY=8, DISCHARGE=16).
// Stimulus queues per-edge expectations; a monitor checks them after each rising edge.
module tb_fire_zone_controller;

    localparam int Z  = 4;
    localparam int CF = 4;
    localparam int DL = 8;
    localparam int DC = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [Z-1:0] smoke = '0, heat = '0, abort = '0;
    logic         ack = 1'b0;
    logic [Z-1:0] alarm, extinguisher;
    logic         any_alarm;
`ifdef FIRE_PREALARM_EN
    logic [Z-1:0] prealarm;
`endif

    fire_zone_controller #(
        .ZONES(Z), .CONFIRM_CYCLES(CF), .DISCHARGE_DELAY(DL), .DISCHARGE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .smoke(smoke), .heat(heat), .abort(abort), .ack(ack),
        .alarm(alarm), .extinguisher(extinguisher),
`ifdef FIRE_PREALARM_EN
        .prealarm(prealarm),
`endif
        .any_alarm(any_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        name;
        logic [Z-1:0] alarm;
        logic [Z-1:0] ext;
        logic         any;
        bit           chk_pre;
        logic [Z-1:0] pre;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [Z-1:0] act, logic [Z-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, expv);
        end
    endtask

    // Queue the expected outputs for the coming edge, then move to the next falling edge.
    task automatic tick(string nm, logic [Z-1:0] a, logic [Z-1:0] e, logic an,
                        bit cp = 1'b0, logic [Z-1:0] pr = '0);
        exp_t x;
        x.cyc = cyc + 1; x.name = nm; x.alarm = a; x.ext = e; x.any = an;
        x.chk_pre = cp; x.pre = pr;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: every edge, compare and retire the expectations due now.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk({sb[i].name, "_alarm"}, alarm, sb[i].alarm);
                    chk({sb[i].name, "_ext"}, extinguisher, sb[i].ext);
                    chk({sb[i].name, "_any"}, {{(Z-1){1'b0}}, any_alarm}, {{(Z-1){1'b0}}, sb[i].any});
`ifdef FIRE_PREALARM_EN
                    if (sb[i].chk_pre) chk({sb[i].name, "_pre"}, prealarm, sb[i].pre);
`endif
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: expectation for cyc %0d never checked (now %0d)", sb[i].name, sb[i].cyc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_alarm", alarm, '0);
        chk("reset_ext", extinguisher, '0);
        chk("reset_any", {{(Z-1){1'b0}}, any_alarm}, '0);
        rst = 1'b0;
        tick("idle", 4'b0000, 4'b0000, 1'b0);

        // Zone 0: full sequence; abort while verifying must not matter.
        smoke = 4'b0001; heat = 4'b0001; abort = 4'b0001;
        repeat (CF - 1) tick("z0_verify", 4'b0000, 4'b0000, 1'b0);
        tick("z0_alarm", 4'b0001, 4'b0000, 1'b1);
        abort = 4'b0000;
        repeat (DL - 1) tick("z0_delay", 4'b0001, 4'b0000, 1'b1);
        repeat (DC) tick("z0_dis", 4'b0001, 4'b0001, 1'b1);
        tick("z0_hold", 4'b0001, 4'b0000, 1'b1);

        // Zone 2 alarms alongside zone 0, aborted at the 5th delay edge.
        smoke = 4'b0101; heat = 4'b0101;
        repeat (CF - 1) tick("z2_verify", 4'b0001, 4'b0000, 1'b1);
        tick("z2_alarm", 4'b0101, 4'b0000, 1'b1);
        smoke = 4'b0001; heat = 4'b0001;
        repeat (4) tick("z2_delay", 4'b0101, 4'b0000, 1'b1);
        abort = 4'b0100;
        tick("z2_abort", 4'b0101, 4'b0000, 1'b1);
        abort = 4'b0000;
        repeat (20) tick("z2_noext", 4'b0101, 4'b0000, 1'b1);
        // ack with zone 0 fire still present: only zone 2 clears.
        ack = 1'b1;
        tick("ack_z2", 4'b0001, 4'b0000, 1'b1);
        tick("ack_z0_fire", 4'b0001, 4'b0000, 1'b1);
        smoke = 4'b0000; heat = 4'b0000;
        tick("ack_z0", 4'b0000, 4'b0000, 1'b0);
        ack = 1'b0;

        // Zone 1: broken confirmation restarts the count.
        smoke = 4'b0010; heat = 4'b0010;
        repeat (CF - 1) tick("z1_verify", 4'b0000, 4'b0000, 1'b0);
        heat = 4'b0000;
        tick("z1_drop", 4'b0000, 4'b0000, 1'b0);
        heat = 4'b0010;
        repeat (CF - 1) tick("z1_reverify", 4'b0000, 4'b0000, 1'b0);
        tick("z1_alarm", 4'b0010, 4'b0000, 1'b1);
        // abort and ack together in ALARM: abort wins, ack only counts next edge.
        smoke = 4'b0000; heat = 4'b0000; abort = 4'b0010; ack = 1'b1;
        tick("z1_abort_ack", 4'b0010, 4'b0000, 1'b1);
        abort = 4'b0000;
        tick("z1_ack", 4'b0000, 4'b0000, 1'b0);
        ack = 1'b0;

        // Zone 3: asynchronous reset mid-discharge.
        smoke = 4'b1000; heat = 4'b1000;
        repeat (CF - 1) tick("z3_verify", 4'b0000, 4'b0000, 1'b0);
        tick("z3_alarm", 4'b1000, 4'b0000, 1'b1);
        repeat (DL - 1) tick("z3_delay", 4'b1000, 4'b0000, 1'b1);
        repeat (5) tick("z3_dis", 4'b1000, 4'b1000, 1'b1);
        smoke = 4'b0000; heat = 4'b0000;
        #2 rst = 1'b1;
        #1;
        chk("arst_alarm", alarm, '0);
        chk("arst_ext", extinguisher, '0);
        chk("arst_any", {{(Z-1){1'b0}}, any_alarm}, '0);
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (5) tick("z3_idle", 4'b0000, 4'b0000, 1'b0);

        // Smoke without heat: prealarm only, never an alarm.
        smoke = 4'b0010;
        tick("pre_on", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010);
        tick("pre_hold", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010);
        smoke = 4'b0000;
        tick("pre_off", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000);

        repeat (2) @(negedge clk);
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: pending expectation for cyc %0d, got none expected check", sb[i].name, sb[i].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
